// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: double-buffered multiplexed seven-segment scanner for a packed BCD word
module bcd_seg_scan #(
    parameter int DECIMAL_DIGITS   = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int GUARD_CYCLES     = 8,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
    input  logic                          i_DV,
    input  logic                          i_Blank_Zeros,
    output logic [6:0]                    o_Segments,
    output logic [DECIMAL_DIGITS-1:0]     o_Anodes,
    output logic                          o_Frame_Done,
    output logic                          o_Invalid
);
    localparam int W  = DECIMAL_DIGITS * 4;
    localparam int IW = DECIMAL_DIGITS > 1 ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int MX = SCAN_DIV > GUARD_CYCLES ? SCAN_DIV : GUARD_CYCLES;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GD_LAST  = CW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DECIMAL_DIGITS - 1);

    typedef enum logic [1:0] {s_BLANK, s_ON, s_GUARD} state_t;

    state_t                   state, nxt_state;
    logic [IW-1:0]            idx, nxt_idx, wrap_idx;
    logic [CW-1:0]            cnt, nxt_cnt;
    logic [W-1:0]             pending, active, nxt_active;
    logic                     pend_valid, boundary;
    logic [6:0]               seg_q, nxt_seg;
    logic [DECIMAL_DIGITS-1:0] an_q, nxt_an;
    logic                     done_q, inv_q;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // True when digit i and every more significant digit are zero
    function automatic logic is_lead_zero(input logic [W-1:0] v, input logic [IW-1:0] i);
        for (int j = 0; j < DECIMAL_DIGITS; j++)
            if (j >= int'(i) && v[4*j +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic has_invalid(input logic [W-1:0] v);
        for (int j = 0; j < DECIMAL_DIGITS; j++)
            if (v[4*j +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // The final slot of the last digit: its guard cycle, or its last lit cycle when there is no guard
    function automatic logic is_last(input state_t s, input logic [IW-1:0] i, input logic [CW-1:0] c);
        return i == IDX_LAST && (GUARD_CYCLES > 0 ? (s == s_GUARD && c == GD_LAST)
                                                  : (s == s_ON && c == ON_LAST));
    endfunction

    // Next-state, frame-boundary buffer swap and next output values
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        wrap_idx  = idx == IDX_LAST ? '0 : idx + 1'b1;
        case (state)
            s_BLANK: if (pend_valid) begin
                nxt_state = s_ON;
                nxt_idx   = '0;
                nxt_cnt   = '0;
            end
            s_ON: if (cnt == ON_LAST) begin
                nxt_cnt = '0;
                if (GUARD_CYCLES > 0) nxt_state = s_GUARD;
                else nxt_idx = wrap_idx;
            end else nxt_cnt = cnt + 1'b1;
            s_GUARD: if (cnt == GD_LAST) begin
                nxt_state = s_ON;
                nxt_idx   = wrap_idx;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + 1'b1;
            default: nxt_state = s_BLANK;
        endcase
        boundary   = (state == s_BLANK && pend_valid) || (state != s_BLANK && is_last(state, idx, cnt));
        nxt_active = boundary ? (i_DV ? i_BCD : pend_valid ? pending : active) : active;
        nxt_an     = nxt_state == s_ON ? DECIMAL_DIGITS'(1) << nxt_idx : '0;
        nxt_seg    = (nxt_state != s_ON ||
                      (i_Blank_Zeros && nxt_idx != '0 && is_lead_zero(nxt_active, nxt_idx)))
                     ? 7'h00 : decode(nxt_active[4*int'(nxt_idx) +: 4]);
    end

    // Scan state, capture buffers and registered display outputs
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= s_BLANK;
            idx        <= '0;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            pend_valid <= 1'b0;
            seg_q      <= '0;
            an_q       <= '0;
            done_q     <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            active     <= nxt_active;
            if (i_DV && !boundary) pending <= i_BCD;
            pend_valid <= boundary ? 1'b0 : (i_DV | pend_valid);
            seg_q      <= nxt_seg;
            an_q       <= nxt_an;
            done_q     <= is_last(nxt_state, nxt_idx, nxt_cnt);
            if (boundary) inv_q <= has_invalid(nxt_active);
        end
    end

    assign o_Segments   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign o_Anodes     = DIGIT_ACTIVE_LOW ? ~an_q : an_q;
    assign o_Frame_Done = done_q;
    assign o_Invalid    = inv_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed checks of scan timing, blanking, double buffering and reset
module tb_bcd_seg_scan;
    logic        clk, rst_n, dv, blank;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fd, inv;
    int          errors = 0;
    int          checks = 0;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bcd_seg_scan #(
        .DECIMAL_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd), .i_DV(dv),
        .i_Blank_Zeros(blank), .o_Segments(seg), .o_Anodes(an),
        .o_Frame_Done(fd), .o_Invalid(inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("idle_anodes", 32'(an), 32'hF);
            chk("idle_segments", 32'(seg), 32'h7F);
            chk("idle_frame_done", 32'(fd), 32'h0);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        bcd = v;
        dv  = 1'b1;
        @(negedge clk);
        dv  = 1'b0;
        chk("pending_only_anodes", 32'(an), 32'hF);
    endtask

    // One 20-cycle frame showing val; optional strobes issued after the checks of cycles a1/a2
    task automatic frame(input logic [15:0] val, input logic bz,
                         input int a1, input logic [15:0] v1, input int a2, input logic [15:0] v2);
        logic [6:0] s;
        logic [3:0] a;
        logic       bad;
        int         slot, ph;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) if (val[4*k +: 4] > 4'd9) bad = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dv   = 1'b0;
            slot = c / 5;
            ph   = c % 5;
            if (ph < 4) begin
                a = ~(4'b0001 << slot);
                s = (bz && slot > 0 && (val >> (4 * slot)) == 16'h0) ? 7'h7F : ~SEG[val[4*slot +: 4]];
            end else begin
                a = 4'hF;
                s = 7'h7F;
            end
            chk($sformatf("anodes_%h_c%0d", val, c), 32'(an), 32'(a));
            chk($sformatf("segments_%h_c%0d", val, c), 32'(seg), 32'(s));
            chk($sformatf("frame_done_%h_c%0d", val, c), 32'(fd), 32'(c == 19));
            chk($sformatf("invalid_%h_c%0d", val, c), 32'(inv), 32'(bad));
            if (c == a1) begin dv = 1'b1; bcd = v1; end
            if (c == a2) begin dv = 1'b1; bcd = v2; end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dv    = 1'b0;
        bcd   = 16'h0;
        blank = 1'b0;
        #12;
        chk("reset_anodes", 32'(an), 32'hF);
        chk("reset_segments", 32'(seg), 32'h7F);
        chk("reset_frame_done", 32'(fd), 32'h0);
        chk("reset_invalid", 32'(inv), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        strobe(16'h1234);
        frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0);
        frame(16'h1234, 1'b0, 19, 16'h0007, -1, 16'h0);
        blank = 1'b1;
        frame(16'h0007, 1'b1, -1, 16'h0, -1, 16'h0);
        blank = 1'b0;
        frame(16'h0007, 1'b0, 12, 16'h1234, 15, 16'h5678);
        frame(16'h5678, 1'b0, 5, 16'h00A5, -1, 16'h0);
        frame(16'h00A5, 1'b0, 3, 16'h0005, -1, 16'h0);
        frame(16'h0005, 1'b0, -1, 16'h0, -1, 16'h0);
        @(negedge clk);
        chk("pre_reset_anodes", 32'(an), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_anodes", 32'(an), 32'hF);
        chk("async_reset_segments", 32'(seg), 32'h7F);
        chk("async_reset_frame_done", 32'(fd), 32'h0);
        chk("async_reset_invalid", 32'(inv), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        blank = 1'b1;
        strobe(16'h0042);
        frame(16'h0042, 1'b1, -1, 16'h0, -1, 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
